// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch front-end.
//   XLEN_DEFAULT  : address / instruction width used by fetch_entry_t
//   INST_NOP      : canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t : one buffered fetch result {pc, inst}
//   pc_next()     : sequential successor of a word-aligned PC
package fetch_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam logic [XLEN_DEFAULT-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] inst;
   } fetch_entry_t;

   // Wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
   function automatic logic [XLEN_DEFAULT-1:0] pc_next(input logic [XLEN_DEFAULT-1:0] pc);
      return pc + XLEN_DEFAULT'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   flush      : empties the FIFO and resets both pointers (wins over push/pop)
//   push       : write push_data at the tail (ignored when full without a pop)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (storage contents when empty)
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          pop_eff;
   logic          push_eff;

   always_comb begin
      pop_eff  = pop && (count != '0);
      push_eff = push && ((count != DEPTH_C) || pop_eff);
   end

   assign head = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_eff && !pop_eff) begin
            count <= count + CW'(1);
         end else if (pop_eff && !push_eff) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: instruction fetch front-end feeding the core.
// Issues pipelined req/gnt requests to instruction memory, buffers in-order
// rvalid responses in a fetch_fifo and presents {pc, inst} to the core over
// a valid/ready handshake. A redirect flushes the buffer and marks every
// in-flight response for discard.
// Ports:
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   redirect_valid/pc    : restart fetch at redirect_pc (bits [1:0] cleared)
//   imem_req/addr        : request valid / word address (held while !gnt)
//   imem_gnt             : request accepted this cycle
//   imem_rvalid/rdata    : in-order response valid / instruction
//   inst_valid/ready     : head entry available / consumed by core
//   inst_data/pc         : head instruction and its PC
//   busy                 : responses still outstanding (including discards)
module fetch_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEFAULT,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   count;
   logic            started;

   logic            accept;
   logic            rsp;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_aligned;
   logic [CW-1:0]   outstanding_nxt;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // Credit check: every request in flight reserves a FIFO slot, so a
   // response can always be pushed without back-pressure.
   always_comb begin
      imem_req = started && !redirect_valid &&
                 (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
      imem_addr = fetch_pc;
      accept    = imem_req && imem_gnt;
      // A response with nothing outstanding is a protocol violation; drop it.
      rsp       = imem_rvalid && (outstanding != '0);
      push      = rsp && (discard == '0) && !redirect_valid;
      pop       = inst_valid && inst_ready;
      redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
      outstanding_nxt  = outstanding + CW'(accept) - CW'(rsp);
      push_entry = '{pc: resp_pc, inst: imem_rdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         started <= 1'b0;
      end else begin
         started <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the
            // old stream, including a same-cycle accept; a same-cycle
            // response is already dropped via push.
            fetch_pc <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            discard  <= outstanding_nxt;
         end else begin
            if (accept) begin
               fetch_pc <= pc_next(fetch_pc);
            end
            if (rsp && (discard != '0)) begin
               discard <= discard - CW'(1);
            end
            if (push) begin
               resp_pc <= pc_next(resp_pc);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // When empty, inst_pc shows the PC of the next expected response.
   always_comb begin
      inst_valid = (count != '0);
      inst_data  = head.inst;
      inst_pc    = inst_valid ? head.pc : resp_pc;
      busy       = (outstanding != '0);
   end

`ifndef SYNTHESIS
   a_count_le_depth : assert property (@(posedge clk) disable iff (reset)
      ({1'b0, count} <= DEPTH_W))
      else $error("fifo count exceeds DEPTH");
   a_credit : assert property (@(posedge clk) disable iff (reset)
      (({1'b0, count} + {1'b0, outstanding}) <= DEPTH_W))
      else $error("count + outstanding exceeds DEPTH");
   a_stray_rvalid : assert property (@(posedge clk) disable iff (reset)
      (imem_rvalid |-> (outstanding != '0)))
      else $warning("rvalid with no request outstanding ignored");
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
module tb_fetch_prefetch_buffer;
   import fetch_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        busy;

   always #5 clk = ~clk;

   fetch_prefetch_buffer #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .busy           (busy)
   );

   // Reference model: requests granted but not yet answered (with a flag
   // for those that belong to a stream killed by a redirect), and the PCs
   // the core should still receive, in order.
   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          cyc;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] fq[$];
   logic [31:0] exp_fetch;
   bit          started_m;
   int          cyc;
   int          step_no;
   int          first_req_step;
   int          first_valid_step;
   int          grants_seen;
   bit          stray_rv;
   int          gnt_pct, rv_pct, rdy_pct, redir_pct;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ INST_NOP;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      fq.delete();
      exp_fetch = RESET_PC;
      started_m = 1'b0;
      step_no   = 0;
      first_req_step   = -1;
      first_valid_step = -1;
   endtask

   task automatic step(input bit force_redir, input logic [31:0] tgt);
      bit    exp_req;
      bit    acc;
      mreq_t r;
      @(negedge clk);
      redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
      redirect_pc    = force_redir ? tgt : $urandom;
      imem_gnt       = ($urandom_range(99) < gnt_pct);
      inst_ready     = ($urandom_range(99) < rdy_pct);
      imem_rvalid    = 1'b0;
      imem_rdata     = $urandom;
      if (mq.size() != 0) begin
         if (mq[0].cyc < cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
         end
      end else if (stray_rv) begin
         imem_rvalid = 1'b1;
      end
      #1;
      exp_req = started_m && !redirect_valid && ((mq.size() + fq.size()) < DEPTH);
      check_eq("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check_eq("imem_addr", imem_addr, exp_fetch);
      check_eq("busy", 32'(busy), 32'(mq.size() != 0));
      check_eq("inst_valid", 32'(inst_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
         check_eq("inst_pc", inst_pc, fq[0]);
         check_eq("inst_data", inst_data, mem_word(fq[0]));
      end
      if (imem_req && first_req_step < 0) first_req_step = step_no;
      if (inst_valid && first_valid_step < 0) first_valid_step = step_no;
      if (imem_req && imem_gnt) grants_seen++;
      acc = exp_req && imem_gnt;

      @(posedge clk);
      if (fq.size() != 0 && inst_ready) void'(fq.pop_front());
      if (imem_rvalid && mq.size() != 0) begin
         r = mq.pop_front();
         if (!r.stale && !redirect_valid) fq.push_back(r.addr);
      end
      if (redirect_valid) begin
         fq.delete();
         foreach (mq[i]) mq[i].stale = 1'b1;
         exp_fetch = {redirect_pc[31:2], 2'b00};
      end
      if (acc) begin
         mq.push_back('{addr: exp_fetch, stale: 1'b0, cyc: cyc});
         exp_fetch = exp_fetch + 32'd4;
      end
      started_m = 1'b1;
      cyc++;
      step_no++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0);
   endtask

   task automatic knobs(input int g, input int rv, input int rdy, input int rd);
      gnt_pct = g; rv_pct = rv; rdy_pct = rdy; redir_pct = rd;
   endtask

   initial begin
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      inst_ready = 1'b0;
      stray_rv = 1'b0;
      cyc = 0;
      grants_seen = 0;
      model_reset();
      knobs(100, 100, 100, 0);
      #1;
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_addr", imem_addr, RESET_PC);
      check_eq("rst_valid", 32'(inst_valid), 32'd0);
      check_eq("rst_data", inst_data, 32'd0);
      check_eq("rst_pc", inst_pc, RESET_PC);
      check_eq("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // Streaming start-up latency and bubble-free delivery.
      run(12);
      check_eq("first_req_step", 32'(first_req_step), 32'd1);
      check_eq("first_valid_step", 32'(first_valid_step), 32'd3);

      // Credit limit with a stalled core, then drain.
      knobs(100, 100, 0, 0);
      step(1'b1, 32'h0000_0200);
      grants_seen = 0;
      run(10);
      check_eq("credit_grants", 32'(grants_seen), 32'd4);
      knobs(100, 100, 100, 0);
      run(8);

      // Redirect with requests in flight; unaligned target.
      knobs(100, 0, 100, 0);
      run(2);
      step(1'b1, 32'h0000_0103);
      knobs(100, 100, 100, 0);
      run(8);

      // Grant stall: address must hold.
      knobs(0, 100, 100, 0);
      run(3);
      knobs(100, 100, 100, 0);
      run(3);

      // Wrap-around of the fetch address.
      step(1'b1, 32'hFFFF_FFFC);
      run(8);

      // Random traffic with occasional redirects.
      knobs(70, 60, 70, 3);
      run(3000);

      // Reset in the middle of traffic.
      knobs(100, 0, 0, 0);
      run(3);
      knobs(100, 100, 0, 0);
      run(1);
      knobs(100, 0, 0, 0);
      run(2);
      @(negedge clk);
      redirect_valid = 1'b0;
      imem_rvalid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_req", 32'(imem_req), 32'd0);
      check_eq("mid_rst_addr", imem_addr, RESET_PC);
      check_eq("mid_rst_valid", 32'(inst_valid), 32'd0);
      check_eq("mid_rst_data", inst_data, 32'd0);
      check_eq("mid_rst_pc", inst_pc, RESET_PC);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      knobs(100, 100, 100, 0);
      stray_rv = 1'b1;
      step(1'b0, 32'h0);
      stray_rv = 1'b0;
      run(12);
      check_eq("post_rst_first_valid", 32'(first_valid_step), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
Instruction fetch front-end placed directly upstream of the processor core's instruction input. It replaces the core's direct PC-to-instruction-memory path. It issues pipelined requests to an instruction memory over a req/gnt + rvalid interface and buffers returned instructions in a small FIFO. It presents {pc, instruction} to the core over a valid/ready handshake and flushes cleanly on a control-flow redirect.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, FIFO entries; power of two, >= 2; also the maximum number of requests in flight plus entries buffered
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] forced to 0
imem_req  out  1  request valid
imem_addr  out  XLEN  request word address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order, >= 1 cycle after grant
imem_rdata  in  XLEN  response instruction
inst_valid  out  1  head entry available to core
inst_ready  in  1  core consumes head entry
inst_data  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction
busy  out  1  one or more requests outstanding (including discards)

Behaviour:
- Reset (asynchronous, immediate) sets the following:
  - fetch_pc = resp_pc = RESET_PC.
  - count = outstanding = discard = 0; started = 0.
  - FIFO storage = 0; imem_req = 0; imem_addr = RESET_PC.
  - inst_valid = 0; inst_data = 0; inst_pc = RESET_PC; busy = 0.
- started flop sets on the first clock after reset deasserts. imem_req stays low until started = 1.
- imem_req = started && !redirect_valid && (count + outstanding < DEPTH). This credit rule guarantees the FIFO never overflows. imem_addr = fetch_pc.
- Accept (req && gnt): fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0); outstanding += 1.
- While req && !gnt, imem_addr is held stable.
- Response (rvalid) handling:
  - Decrement outstanding.
  - If discard > 0: decrement discard and drop the data.
  - Otherwise: push {resp_pc, rdata} into the FIFO and increment resp_pc by 4.
  - rvalid with outstanding == 0 is a protocol violation and is ignored (simulation assertion).
- No bypass path. Response in cycle N is visible on inst_valid no earlier than cycle N+1.
- Output side:
  - inst_valid = (count != 0); inst_data/inst_pc come from the FIFO head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leaves count unchanged.
- Redirect (redirect_valid high for one cycle):
  - FIFO is flushed: count = 0, read/write pointers reset. A same-cycle pop is irrelevant.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard = outstanding + (same-cycle accept ? 1 : 0) - (same-cycle rvalid ? 1 : 0). The same-cycle rvalid is itself dropped.
  - imem_req is low that cycle; fetching resumes the next cycle.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Counter widths are $clog2(DEPTH)+1. Simulation assertions: count <= DEPTH, count + outstanding <= DEPTH.
- No state machine beyond reset/started. Behaviour is counter-driven.

Decomposition:
- fetch_pkg holds:
  - XLEN_DEFAULT;
  - INST_NOP = 32'h0000_0013;
  - typedef fetch_entry_t {pc, inst};
  - function pc_next (pc + 4).
- One sub-module, fetch_fifo: parameterised DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head output. It is reused later for decode skid buffering.

Test Plan:
- Release reset, gnt = 1, rvalid one cycle after each grant, inst_ready = 1 -> imem_req first high 1 cycle after deassert; inst_valid first high 3 cycles after deassert; inst_pc = 0x0, 0x4, 0x8 with matching data; no bubbles thereafter.
- inst_ready = 0, DEPTH = 4 -> exactly 4 grants, then imem_req low; count = 4. Raise ready -> one entry drained per cycle and requests resume.
- Two requests outstanding, redirect_pc = 0x103 -> next two rvalids dropped; first delivered inst_pc = 0x100; busy clears after the second dropped response.
- imem_gnt low 3 cycles with req high -> imem_addr held at 0x8 throughout; accepted on the 4th cycle; next address 0xC.
- Redirect to 0xFFFF_FFFC -> delivered pcs 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Assert reset with 3 outstanding and 2 buffered -> all outputs take reset values immediately. Stray rvalid after release is ignored; the first delivered pc is RESET_PC.
